// File: rtl/mem_wb_pkg.sv
// Shared types and constants for the load/store unit: FSM states, funct3 encodings and access sizes.
package mem_wb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WB     = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } size_e;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  // The low two funct3 bits encode the access size for both loads and stores.
  function automatic size_e size_of(input logic [1:0] f3_lo);
    case (f3_lo)
      2'b00:   return BYTE;
      2'b01:   return HALF;
      default: return WORD;
    endcase
  endfunction

  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    if (is_store) return (f3 == SB) || (f3 == SH) || (f3 == SW);
    return (f3 == LB) || (f3 == LH) || (f3 == LW) || (f3 == LBU) || (f3 == LHU);
  endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/half lane of a memory read word and sign/zero extends it per funct3.
module load_extend
  import mem_wb_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] value
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = 8'(rdata >> {addr, 3'b000});
  assign w_half = 16'(rdata >> {addr[1], 4'b0000});

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    value = '0;
    case (funct3)
      LB:      value = {{24{w_byte[7]}}, w_byte};
      LH:      value = {{16{w_half[15]}}, w_half};
      LW:      value = rdata;
      LBU:     value = {24'h0, w_byte};
      LHU:     value = {16'h0, w_half};
      default: value = '0;
    endcase
  end

endmodule

// File: rtl/mem_wb_unit.sv
// Load/store unit: one memory access per start, then a single writeback/completion cycle.
// Optional build macro MEM_WB_MISALIGN_TRAP_EN traps misaligned half/word accesses instead of dropping low address bits.
module mem_wb_unit
  import mem_wb_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rd_in,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_wdata
);

  localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (ACK_TIMEOUT > 0) ? CNT_W'(ACK_TIMEOUT - 1) : '0;

  state_e           r_state;
  logic             r_is_store;
  logic [2:0]       r_funct3;
  logic [4:0]       r_rd;
  logic [31:0]      r_addr;
  logic [31:0]      r_store_data;
  logic             r_err;
  logic [31:0]      r_load_val;
  logic [CNT_W-1:0] r_cnt;

  state_e      w_next_state;
  logic        w_misalign;
  logic        w_start_ok;
  logic        w_timeout;
  size_e       w_size;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_load_val;

`ifdef MEM_WB_MISALIGN_TRAP_EN
  always_comb begin
    w_misalign = 1'b0;
    case (size_of(funct3[1:0]))
      HALF:    w_misalign = addr[0];
      WORD:    w_misalign = (addr[1:0] != 2'b00);
      default: w_misalign = 1'b0;
    endcase
  end
`else
  assign w_misalign = 1'b0;
`endif

  assign w_start_ok = f3_legal(is_store, funct3) && !w_misalign;

  always_comb begin
    w_next_state = r_state;
    w_timeout    = 1'b0;
    case (r_state)
      IDLE:    if (start) w_next_state = w_start_ok ? ACCESS : WB;
      ACCESS: begin
        w_timeout = (ACK_TIMEOUT != 0) && !mem_ack && (r_cnt == CNT_LAST);
        if (mem_ack || w_timeout) w_next_state = WB;
      end
      WB:      w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state is updated with non-blocking assignments only.
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  load_extend u_load_extend (
    .rdata  (mem_rdata),
    .addr   (r_addr[1:0]),
    .funct3 (r_funct3),
    .value  (w_load_val)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_is_store   <= 1'b0;
      r_funct3     <= '0;
      r_rd         <= '0;
      r_addr       <= '0;
      r_store_data <= '0;
      r_err        <= 1'b0;
      r_load_val   <= '0;
      r_cnt        <= '0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_is_store   <= is_store;
          r_funct3     <= funct3;
          r_rd         <= rd_in;
          r_addr       <= addr;
          r_store_data <= store_data;
          r_err        <= !w_start_ok;
          r_load_val   <= '0;
          r_cnt        <= '0;
        end
        ACCESS: begin
          if (mem_ack) begin
            if (!r_is_store) r_load_val <= w_load_val;
          end else if (w_timeout) begin
            r_err <= 1'b1;
          end
          r_cnt <= (mem_ack || w_timeout) ? '0 : r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign w_size = size_of(r_funct3[1:0]);

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = r_store_data;
    case (w_size)
      BYTE: begin
        w_be    = 4'b0001 << r_addr[1:0];
        w_wdata = {4{r_store_data[7:0]}};
      end
      HALF: begin
        w_be    = 4'b0011 << {r_addr[1], 1'b0};
        w_wdata = {2{r_store_data[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = r_store_data;
      end
    endcase
  end

  // Bus and regfile outputs are gated by state so they read as zero outside their cycle.
  assign busy      = (r_state != IDLE);
  assign done      = (r_state == WB);
  assign err       = done && r_err;
  assign mem_req   = (r_state == ACCESS);
  assign mem_we    = mem_req && r_is_store;
  assign mem_addr  = mem_req ? {r_addr[31:2], 2'b00} : '0;
  assign mem_be    = mem_req ? w_be : '0;
  assign mem_wdata = (mem_req && r_is_store) ? w_wdata : '0;
  assign rf_we     = done && !r_is_store && !r_err && (r_rd != 5'd0);
  assign rf_rd     = done ? r_rd : '0;
  assign rf_wdata  = done ? r_load_val : '0;

endmodule

// File: tb/tb_mem_wb_unit.sv
// Self-checking bench for mem_wb_unit: vector table with a completion scoreboard plus reset corner sequences.
module tb_mem_wb_unit;
  import mem_wb_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [4:0]  rd_in = '0;
  logic [31:0] addr = '0;
  logic [31:0] store_data = '0;
  logic        busy, done, err;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;

  mem_wb_unit #(.ACK_TIMEOUT(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .is_store   (is_store),
    .funct3     (funct3),
    .rd_in      (rd_in),
    .addr       (addr),
    .store_data (store_data),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .rf_we      (rf_we),
    .rf_rd      (rf_rd),
    .rf_wdata   (rf_wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_store;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic [31:0] rdata;
    int          ack_at;     // cycle in which mem_ack is driven high, 0 = never
    logic        hold;       // keep start high until after done
    logic [31:0] e_maddr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic        e_err;
    logic        e_rfwe;
    logic [31:0] e_rfwdata;
    int          e_done;
    int          e_req;
  } vec_t;

  typedef struct {
    logic        err;
    logic        rf_we;
    logic [4:0]  rd;
    logic [31:0] wdata;
    int          done_cyc;
    int          req_cyc;
  } exp_t;

  localparam int NV = 15;
  vec_t vecs[NV];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    exp_t e;
    exp_t got;
    int   req_cyc;
    bit   seen;
    is_store   = v.is_store;
    funct3     = v.f3;
    addr       = v.addr;
    store_data = v.sd;
    rd_in      = v.rd;
    start      = 1'b1;
    e.err      = v.e_err;
    e.rf_we    = v.e_rfwe;
    e.rd       = v.rd;
    e.wdata    = v.e_rfwdata;
    e.done_cyc = v.e_done;
    e.req_cyc  = v.e_req;
    sb.push_back(e);
    req_cyc = 0;
    seen    = 1'b0;
    for (int cyc = 1; cyc <= 40 && !seen; cyc++) begin
      @(posedge clk); #1;
      if (!v.hold) start = 1'b0;
      mem_ack   = 1'b0;
      mem_rdata = 32'hBAD0_BAD0;
      if (mem_req) begin
        req_cyc++;
        check($sformatf("v%0d_mem_addr", idx), mem_addr, v.e_maddr);
        check($sformatf("v%0d_mem_be", idx), {28'h0, mem_be}, {28'h0, v.e_be});
        check($sformatf("v%0d_mem_we", idx), {31'h0, mem_we}, {31'h0, v.is_store});
        if (v.is_store) check($sformatf("v%0d_mem_wdata", idx), mem_wdata, v.e_wdata);
        if (cyc == v.ack_at) begin
          mem_ack   = 1'b1;
          mem_rdata = v.rdata;
        end
      end
      if (done) begin
        got = sb.pop_front();
        check($sformatf("v%0d_err", idx), {31'h0, err}, {31'h0, got.err});
        check($sformatf("v%0d_rf_we", idx), {31'h0, rf_we}, {31'h0, got.rf_we});
        if (got.rf_we) begin
          check($sformatf("v%0d_rf_rd", idx), {27'h0, rf_rd}, {27'h0, got.rd});
          check($sformatf("v%0d_rf_wdata", idx), rf_wdata, got.wdata);
        end
        check($sformatf("v%0d_done_cycle", idx), cyc, got.done_cyc);
        check($sformatf("v%0d_req_cycles", idx), req_cyc, got.req_cyc);
        seen = 1'b1;
      end
    end
    mem_ack = 1'b0;
    if (!seen) begin
      n_cmp++;
      n_fail++;
      $display("FAIL v%0d_done_timeout: got no done expected done within 40 cycles", idx);
      if (sb.size() > 0) sb.delete(sb.size() - 1);
    end
    // A start still high in the WB cycle must not launch anything.
    @(posedge clk); #1;
    start = 1'b0;
    check($sformatf("v%0d_after_done", idx), {31'h0, done}, 32'h0);
    check($sformatf("v%0d_after_busy", idx), {31'h0, busy}, 32'h0);
  endtask

  task automatic reset_mid_access();
    is_store = 1'b0;
    funct3   = LW;
    addr     = 32'h0000_0300;
    rd_in    = 5'd4;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("rst_mid_req_before", {31'h0, mem_req}, 32'h1);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("rst_mid_mem_req", {31'h0, mem_req}, 32'h0);
    check("rst_mid_busy", {31'h0, busy}, 32'h0);
    check("rst_mid_mem_addr", mem_addr, 32'h0);
    check("rst_mid_rf_we", {31'h0, rf_we}, 32'h0);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      check("rst_mid_no_done", {31'h0, done}, 32'h0);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_idle_done", {31'h0, done}, 32'h0);
    check("rst_mid_idle_rf_we", {31'h0, rf_we}, 32'h0);
  endtask

  initial begin
    vecs[0]  = '{1'b0, LB,  32'h103, 32'h0,        5'd5,  32'h80FF_1234, 1, 1'b0, 32'h100, 4'b1000, 32'h0,        1'b0, 1'b1, 32'hFFFF_FF80, 2, 1};
    vecs[1]  = '{1'b1, SH,  32'h202, 32'h0000_ABCD, 5'd9,  32'h0,        1, 1'b0, 32'h200, 4'b1100, 32'hABCD_ABCD, 1'b0, 1'b0, 32'h0,        2, 1};
    vecs[2]  = '{1'b0, LBU, 32'h101, 32'h0,        5'd7,  32'h1122_8344, 2, 1'b0, 32'h100, 4'b0010, 32'h0,        1'b0, 1'b1, 32'h0000_0083, 3, 2};
    vecs[3]  = '{1'b0, LH,  32'h012, 32'h0,        5'd31, 32'h9ABC_0000, 1, 1'b0, 32'h010, 4'b1100, 32'h0,        1'b0, 1'b1, 32'hFFFF_9ABC, 2, 1};
    vecs[4]  = '{1'b0, LHU, 32'h010, 32'h0,        5'd2,  32'h1234_F00D, 3, 1'b0, 32'h010, 4'b0011, 32'h0,        1'b0, 1'b1, 32'h0000_F00D, 4, 3};
    vecs[5]  = '{1'b0, LW,  32'h200, 32'h0,        5'd1,  32'hDEAD_BEEF, 1, 1'b0, 32'h200, 4'b1111, 32'h0,        1'b0, 1'b1, 32'hDEAD_BEEF, 2, 1};
    vecs[6]  = '{1'b0, LW,  32'h204, 32'h0,        5'd0,  32'h1234_5678, 1, 1'b0, 32'h204, 4'b1111, 32'h0,        1'b0, 1'b0, 32'h0,        2, 1};
    vecs[7]  = '{1'b1, SB,  32'h003, 32'h1234_5678, 5'd0,  32'h0,        1, 1'b0, 32'h000, 4'b1000, 32'h7878_7878, 1'b0, 1'b0, 32'h0,        2, 1};
    vecs[8]  = '{1'b1, SW,  32'h040, 32'hCAFE_F00D, 5'd0,  32'h0,        2, 1'b0, 32'h040, 4'b1111, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0,        3, 2};
    vecs[9]  = '{1'b0, LB,  32'h001, 32'h0,        5'd12, 32'h0000_7F00, 1, 1'b0, 32'h000, 4'b0010, 32'h0,        1'b0, 1'b1, 32'h0000_007F, 2, 1};
    vecs[10] = '{1'b0, 3'b011, 32'h100, 32'h0,     5'd5,  32'h0,        0, 1'b0, 32'h0,   4'b0000, 32'h0,        1'b1, 1'b0, 32'h0,        1, 0};
    vecs[11] = '{1'b1, 3'b100, 32'h100, 32'h1,     5'd5,  32'h0,        0, 1'b0, 32'h0,   4'b0000, 32'h0,        1'b1, 1'b0, 32'h0,        1, 0};
    vecs[12] = '{1'b0, LW,  32'h300, 32'h0,        5'd8,  32'h0BAD_F00D, 5, 1'b1, 32'h300, 4'b1111, 32'h0,        1'b0, 1'b1, 32'h0BAD_F00D, 6, 5};
    vecs[13] = '{1'b0, LW,  32'h400, 32'h0,        5'd6,  32'h5555_5555, 0, 1'b0, 32'h400, 4'b1111, 32'h0,        1'b1, 1'b0, 32'h0,        17, 16};
`ifdef MEM_WB_MISALIGN_TRAP_EN
    vecs[14] = '{1'b0, LW,  32'h102, 32'h0,        5'd3,  32'h0102_0304, 1, 1'b0, 32'h0,   4'b0000, 32'h0,        1'b1, 1'b0, 32'h0,        1, 0};
`else
    vecs[14] = '{1'b0, LW,  32'h102, 32'h0,        5'd3,  32'h0102_0304, 1, 1'b0, 32'h100, 4'b1111, 32'h0,        1'b0, 1'b1, 32'h0102_0304, 2, 1};
`endif

    reset = 1'b1;
    #1;
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_err", {31'h0, err}, 32'h0);
    check("rst_mem_req", {31'h0, mem_req}, 32'h0);
    check("rst_mem_be", {28'h0, mem_be}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_rf_we", {31'h0, rf_we}, 32'h0);
    check("rst_rf_wdata", rf_wdata, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

    reset_mid_access();
    run_vec(vecs[0], 100);

    check("sb_empty", sb.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
